// File: rtl/spiht_frame_sched.sv
// Ping-pong frame buffer scheduler: writes incoming lines into one of two buffers and
// launches the SPIHT encoder on filled buffers in order. Optional macro: LINE_LENGTH_CHECK_EN.
module spiht_frame_sched #(
    parameter int IMG_WIDTH  = 2048,
    parameter int IMG_HEIGHT = 256,
    parameter int ADDR_W     = 19
) (
    input  logic              PCLK,
    input  logic              RST,
    input  logic [15:0]       Pixel_DATA,
    input  logic              HSYNC,
    output logic              buf_wr_en,
    output logic              buf_wr_sel,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [15:0]       buf_wr_data,
    output logic              enc_start,
    output logic              enc_buf_sel,
    input  logic              enc_done,
    output logic              frame_drop,
    output logic              line_err
);

    localparam int COL_W = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0]  COL_END     = COL_W'(IMG_WIDTH);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(IMG_WIDTH);

    typedef enum logic {W_GAP, W_LINE} wr_state_t;
    typedef enum logic {E_IDLE, E_RUN} enc_state_t;

    wr_state_t        wstate;
    enc_state_t       estate;
    logic [1:0]       full;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;
    logic             wr_sel;
    logic             rd_sel;
    logic             drop;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             line_start;
    logic             line_end;
    logic             frame_start;
    logic             frame_end;
    logic             drop_now;

    // The first pixel of a frame arrives with the rising edge, so the drop decision
    // must already apply in that cycle rather than waiting for the registered flag.
    always_comb begin
        line_start  = HSYNC && (wstate == W_GAP);
        line_end    = !HSYNC && (wstate == W_LINE);
        frame_start = line_start && (row == '0);
        frame_end   = line_end && (row == ROW_LAST);
        drop_now    = frame_start ? full[wr_sel] : drop;
        full_set    = '0;
        if (frame_end && !drop) full_set[wr_sel] = 1'b1;
        full_clr    = '0;
        if ((estate == E_RUN) && enc_done) full_clr[rd_sel] = 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (RST) begin
            wstate      <= W_GAP;
            estate      <= E_IDLE;
            full        <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            drop        <= 1'b0;
            col         <= '0;
            row         <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_sel  <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            enc_start   <= 1'b0;
            enc_buf_sel <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            buf_wr_en  <= 1'b0;
            enc_start  <= 1'b0;
            frame_drop <= frame_start && full[wr_sel];
            // Set and clear always hit different buffers, so both apply together.
            full       <= (full | full_set) & ~full_clr;

            case (wstate)
                W_GAP:   if (HSYNC)  wstate <= W_LINE;
                W_LINE:  if (!HSYNC) wstate <= W_GAP;
                default: wstate <= W_GAP;
            endcase

            if (frame_start) drop <= full[wr_sel];

            if (HSYNC && (col != COL_END)) begin
                col <= col + 1'b1;
                if (!drop_now) begin
                    buf_wr_en   <= 1'b1;
                    buf_wr_sel  <= wr_sel;
                    buf_wr_addr <= ADDR_W'(row) * LINE_STRIDE + ADDR_W'(col);
                    buf_wr_data <= Pixel_DATA;
                end
            end

            if (line_end) begin
                col <= '0;
                if (frame_end) begin
                    row  <= '0;
                    drop <= 1'b0;
                    if (!drop) wr_sel <= ~wr_sel;
                end else begin
                    row <= row + 1'b1;
                end
            end

            case (estate)
                E_IDLE: if (full[rd_sel]) begin
                    enc_start   <= 1'b1;
                    enc_buf_sel <= rd_sel;
                    estate      <= E_RUN;
                end
                E_RUN: if (enc_done) begin
                    rd_sel <= ~rd_sel;
                    estate <= E_IDLE;
                end
                default: estate <= E_IDLE;
            endcase
        end
    end

`ifdef LINE_LENGTH_CHECK_EN
    // col saturates at IMG_WIDTH, so overlong lines need their own counter.
    localparam int CNT_W = $clog2(IMG_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(IMG_WIDTH + 1);
    logic [CNT_W-1:0] px_cnt;

    always_ff @(posedge PCLK) begin
        if (RST) begin
            px_cnt   <= '0;
            line_err <= 1'b0;
        end else begin
            line_err <= line_end && (px_cnt != CNT_FULL);
            if (line_end)
                px_cnt <= '0;
            else if (HSYNC && (px_cnt != CNT_SAT))
                px_cnt <= px_cnt + 1'b1;
        end
    end
`else
    assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_spiht_frame_sched.sv
// Self-checking bench for spiht_frame_sched (4x2 frames) against a frame-level
// model of buffer occupancy, write streams and encoder launch order.
module tb_spiht_frame_sched;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;

    logic          PCLK = 1'b0;
    logic          RST = 1'b1;
    logic [15:0]   Pixel_DATA = '0;
    logic          HSYNC = 1'b0;
    logic          enc_done = 1'b0;
    logic          buf_wr_en, buf_wr_sel, enc_start, enc_buf_sel, frame_drop, line_err;
    logic [AW-1:0] buf_wr_addr;
    logic [15:0]   buf_wr_data;

    always #5 PCLK = ~PCLK;

    spiht_frame_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
        .PCLK(PCLK), .RST(RST), .Pixel_DATA(Pixel_DATA), .HSYNC(HSYNC),
        .buf_wr_en(buf_wr_en), .buf_wr_sel(buf_wr_sel), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .enc_start(enc_start), .enc_buf_sel(enc_buf_sel),
        .enc_done(enc_done), .frame_drop(frame_drop), .line_err(line_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [19:0] exp_wr[$];
    logic [19:0] obs_wr[$];
    int          exp_es[$];
    int          obs_es[$];
    int          exp_fd = 0, obs_fd = 0, exp_le = 0, obs_le = 0, sel_glitch = 0;
    bit          es_act = 1'b0;
    logic        es_hold = 1'b0;

    // Frame-level model: buffer occupancy, write/read pointers, encoder busy.
    bit [1:0]    m_full = '0;
    bit          m_wr = 1'b0, m_rd = 1'b0, m_busy = 1'b0;

    always @(negedge PCLK) begin
        if (buf_wr_en) obs_wr.push_back({buf_wr_sel, buf_wr_addr, buf_wr_data});
        if (enc_start) obs_es.push_back(int'(enc_buf_sel));
        if (frame_drop) obs_fd++;
        if (line_err) obs_le++;
        if (RST) es_act = 1'b0;
        else if (enc_start) begin
            es_act  = 1'b1;
            es_hold = enc_buf_sel;
        end else if (es_act && (enc_buf_sel !== es_hold)) sel_glitch++;
        if (enc_done) es_act = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic try_start();
        if (!m_busy && m_full[m_rd]) begin
            exp_es.push_back(int'(m_rd));
            m_busy = 1'b1;
        end
    endtask

    task automatic clear_books();
        exp_wr.delete(); obs_wr.delete(); exp_es.delete(); obs_es.delete();
        exp_fd = 0; obs_fd = 0; exp_le = 0; obs_le = 0; sel_glitch = 0;
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1; HSYNC = 1'b0; enc_done = 1'b0;
        step();
        chk("rst_wr_en", buf_wr_en, 0);
        chk("rst_wr_sel", buf_wr_sel, 0);
        chk("rst_wr_addr", buf_wr_addr, 0);
        chk("rst_wr_data", buf_wr_data, 0);
        chk("rst_enc_start", enc_start, 0);
        chk("rst_enc_buf_sel", enc_buf_sel, 0);
        chk("rst_frame_drop", frame_drop, 0);
        chk("rst_line_err", line_err, 0);
        repeat (cycles - 1) step();
        RST = 1'b0;
        m_full = '0; m_wr = 1'b0; m_rd = 1'b0; m_busy = 1'b0;
        clear_books();
    endtask

    task automatic send_frame(input int len0, input int len1, input int gap, input bit seq);
        bit drop;
        int len;
        logic [15:0] d;
        drop = m_full[m_wr];
        if (drop) exp_fd++;
        for (int r = 0; r < H; r++) begin
            len = (r == 0) ? len0 : len1;
            for (int c = 0; c < len; c++) begin
                d = seq ? 16'(r * W + c + 1) : 16'($urandom);
                HSYNC = 1'b1;
                Pixel_DATA = d;
                if (!drop && c < W) exp_wr.push_back({m_wr, 3'(r * W + c), d});
                step();
            end
            HSYNC = 1'b0;
`ifdef LINE_LENGTH_CHECK_EN
            if (len != W) exp_le++;
`endif
            repeat (gap) step();
        end
        if (!drop) begin
            m_full[m_wr] = 1'b1;
            m_wr = ~m_wr;
        end
        try_start();
    endtask

    task automatic finish_encode();
        enc_done = 1'b1;
        step();
        enc_done = 1'b0;
        m_full[m_rd] = 1'b0;
        m_rd = ~m_rd;
        m_busy = 1'b0;
        try_start();
    endtask

    task automatic check_all(input string tag);
        int n;
        repeat (4) step();
        chk($sformatf("%s_nwr", tag), obs_wr.size(), exp_wr.size());
        n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_wr%0d", tag, i), obs_wr[i], exp_wr[i]);
        chk($sformatf("%s_nstart", tag), obs_es.size(), exp_es.size());
        n = (obs_es.size() < exp_es.size()) ? obs_es.size() : exp_es.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_startsel%0d", tag, i), obs_es[i], exp_es[i]);
        chk($sformatf("%s_drops", tag), obs_fd, exp_fd);
        chk($sformatf("%s_line_err", tag), obs_le, exp_le);
        chk($sformatf("%s_sel_stable", tag), sel_glitch, 0);
        clear_books();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

    initial begin
        int l0, l1;

        do_reset(2);

        // Directed frame 1..8 into buffer 0, encoder launch inside the trailing gap.
        send_frame(W, W, 3, 1'b1);
        chk("s1_start_latency", obs_es.size(), 1);
        check_all("s1");
        finish_encode();
        repeat (3) step();

        // enc_done just after reset is ignored; two frames fill both buffers, third drops.
        do_reset(1);
        enc_done = 1'b1;
        step();
        enc_done = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(W, W, int'($urandom_range(4, 1)), 1'b0);
        check_all("s2");

        // Releasing buffer 0 launches buffer 1 within two cycles.
        finish_encode();
        repeat (2) step();
        chk("s3_start_latency", obs_es.size(), 1);
        check_all("s3");
        finish_encode();
        send_frame(W, W, 2, 1'b0);
        check_all("s3b");

        // Overlong line, then randomized line lengths, gaps and encoder completion.
        send_frame(6, W, 2, 1'b0);
        check_all("s4");
        for (int f = 0; f < 6; f++) begin
            l0 = int'($urandom_range(6, 2));
            l1 = int'($urandom_range(6, 2));
            send_frame(l0, l1, int'($urandom_range(4, 1)), 1'b0);
            repeat (4) step();
            if (m_busy && ($urandom_range(1, 0) == 1)) finish_encode();
            check_all($sformatf("s5_%0d", f));
        end

        // Reset mid-line abandons the frame; next frame restarts at buffer 0 address 0.
        HSYNC = 1'b1; Pixel_DATA = 16'hAAAA; step();
        Pixel_DATA = 16'h5555; step();
        do_reset(1);
        send_frame(W, W, 2, 1'b1);
        check_all("s6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
